// File: rtl/riscv_ifetch_ctrl.sv
// ============================================================================
// riscv_ifetch_ctrl
// ----------------------------------------------------------------------------
// Instruction-fetch front end for a small in-order RISC-V core. It walks a
// fetch PC through a combinational instruction memory and buffers the
// returned {pc, instr} pairs in a two-entry FIFO for decode. A two-entry
// buffer sustains one instruction per cycle through a stalled decode stage.
// Redirects (branch, jump or trap) flush the buffer and restart fetching
// from the word-aligned target. A redirect target with non-zero low bits
// raises a one-cycle error pulse.
//
// Parameters
//   XLEN           instruction and PC width in bits
//   IMEM_ADDR_BIT  instruction-memory byte-address width
//   RESET_PC       fetch PC loaded on reset
//
// Ports
//   i_clk             rising-edge clock
//   i_rst             synchronous active-high reset
//   o_imem_addr       word address to the instruction memory
//   i_imem_instr      instruction at o_imem_addr, same cycle
//   i_fetch_en        fetch enable; 0 stops new fetches
//   i_redirect_valid  redirect request
//   i_redirect_pc     redirect target byte address
//   o_if_valid        instruction available to decode
//   o_if_instr        instruction at the FIFO head (0 when empty)
//   o_if_pc           byte PC of o_if_instr (0 when empty)
//   i_if_ready        decode accepts the head entry
//   o_fetch_err       one-cycle pulse after a misaligned redirect
// ============================================================================
module riscv_ifetch_ctrl #(
   parameter int unsigned     XLEN          = 32,
   parameter int unsigned     IMEM_ADDR_BIT = 12,
   parameter logic [XLEN-1:0] RESET_PC      = '0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,

   output logic [IMEM_ADDR_BIT-3:0] o_imem_addr,
   input  logic [XLEN-1:0]          i_imem_instr,

   input  logic                     i_fetch_en,
   input  logic                     i_redirect_valid,
   input  logic [XLEN-1:0]          i_redirect_pc,

   output logic                     o_if_valid,
   output logic [XLEN-1:0]          o_if_instr,
   output logic [XLEN-1:0]          o_if_pc,
   input  logic                     i_if_ready,

   output logic                     o_fetch_err
);

   localparam int unsigned CNT_W    = 2;
   localparam int unsigned WORD_LSB = 2;

   // One buffered fetch result
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   logic [XLEN-1:0]    r_fetch_pc;
   entry_t             r_head;      // entry 0: oldest, presented to decode
   entry_t             r_tail;      // entry 1: valid only when count == 2
   logic [CNT_W-1:0]   r_count;
   logic               r_fetch_err;

   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_misaligned;
   logic [XLEN-1:0]    w_redirect_pc_al;
   logic [XLEN-1:0]    w_fetch_pc_inc;
   entry_t             w_new_entry;

   // FIFO status and handshake decode
   assign w_empty = (r_count == CNT_W'(0));
   assign w_full  = (r_count == CNT_W'(2));
   assign w_pop   = !w_empty && i_if_ready;

   // A full FIFO still accepts a fetch when the head leaves in the same cycle
   assign w_push  = (r_state == S_RUN) && i_fetch_en && !i_redirect_valid &&
                    (!w_full || w_pop);

   // Redirect target handling
   assign w_misaligned     = (i_redirect_pc[WORD_LSB-1:0] != '0);
   assign w_redirect_pc_al = {i_redirect_pc[XLEN-1:WORD_LSB], {WORD_LSB{1'b0}}};

   assign w_fetch_pc_inc   = r_fetch_pc + XLEN'(4);
   assign w_new_entry      = '{pc: r_fetch_pc, instr: i_imem_instr};

   // Upper PC bits are dropped, so fetch wraps modulo the memory size
   assign o_imem_addr = r_fetch_pc[IMEM_ADDR_BIT-1:WORD_LSB];

   // Decode-facing view of the FIFO head, forced to zero when empty
   assign o_if_valid  = !w_empty;
   assign o_if_instr  = w_empty ? '0 : r_head.instr;
   assign o_if_pc     = w_empty ? '0 : r_head.pc;
   assign o_fetch_err = r_fetch_err;

   // Fetch FSM, fetch PC, FIFO and error flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_fetch_pc  <= RESET_PC;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_fetch_err <= 1'b0;
      end else begin
         r_fetch_err <= i_redirect_valid && w_misaligned;

         unique case (r_state)
            S_IDLE:  if (i_fetch_en)  r_state <= S_RUN;
            S_RUN:   if (!i_fetch_en) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         if (i_redirect_valid) begin
            // Flush wins over any push; a coincident pop is still a transfer
            r_fetch_pc <= w_redirect_pc_al;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
         end else begin
            if (w_push) begin
               r_fetch_pc <= w_fetch_pc_inc;
            end

            unique case ({w_push, w_pop})
               2'b10: begin
                  if (w_empty) r_head <= w_new_entry;
                  else         r_tail <= w_new_entry;
                  r_count <= r_count + CNT_W'(1);
               end
               2'b01: begin
                  r_head  <= r_tail;
                  r_tail  <= '0;
                  r_count <= r_count - CNT_W'(1);
               end
               2'b11: begin
                  // Count is unchanged; the new entry lands behind what remains
                  if (w_full) begin
                     r_head <= r_tail;
                     r_tail <= w_new_entry;
                  end else begin
                     r_head <= w_new_entry;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_riscv_ifetch_ctrl.sv
// ============================================================================
// tb_riscv_ifetch_ctrl
// ----------------------------------------------------------------------------
// Bench for riscv_ifetch_ctrl with a behavioural instruction memory
// (word n holds 32'h1000_0000 + n) and a queue-based reference model.
// ============================================================================
module tb_riscv_ifetch_ctrl;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned IMEM_ADDR_BIT = 12;

   logic                     clk;
   logic                     i_rst;
   logic [IMEM_ADDR_BIT-3:0] o_imem_addr;
   logic [XLEN-1:0]          i_imem_instr;
   logic                     i_fetch_en;
   logic                     i_redirect_valid;
   logic [XLEN-1:0]          i_redirect_pc;
   logic                     o_if_valid;
   logic [XLEN-1:0]          o_if_instr;
   logic [XLEN-1:0]          o_if_pc;
   logic                     i_if_ready;
   logic                     o_fetch_err;

   riscv_ifetch_ctrl #(
      .XLEN          (XLEN),
      .IMEM_ADDR_BIT (IMEM_ADDR_BIT),
      .RESET_PC      (32'h0000_0000)
   ) dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .o_imem_addr      (o_imem_addr),
      .i_imem_instr     (i_imem_instr),
      .i_fetch_en       (i_fetch_en),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_if_valid       (o_if_valid),
      .o_if_instr       (o_if_instr),
      .o_if_pc          (o_if_pc),
      .i_if_ready       (i_if_ready),
      .o_fetch_err      (o_fetch_err)
   );

   // Combinational instruction memory
   assign i_imem_instr = 32'h1000_0000 + 32'(o_imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc  = 32'h0;
   bit          m_run = 1'b0;
   bit          m_err = 1'b0;

   function automatic logic [31:0] imem_word(input logic [31:0] pc);
      return 32'h1000_0000 + ((pc >> 2) & 32'h3FF);
   endfunction

   // Advance the model across one clock edge with the given inputs
   task automatic model_edge(input bit rst, input bit en, input bit rv,
                             input logic [31:0] rpc, input bit rdy);
      bit pop, push;
      ent_t e;
      if (rst) begin
         m_q.delete();
         m_pc  = 32'h0;
         m_run = 1'b0;
         m_err = 1'b0;
         return;
      end
      pop  = (m_q.size() != 0) && rdy;
      push = m_run && en && !rv && ((m_q.size() < 2) || pop);
      m_err = rv && (rpc[1:0] != 2'b00);
      if (pop) void'(m_q.pop_front());
      if (rv) begin
         m_q.delete();
         m_pc = rpc & ~32'h3;
      end else if (push) begin
         e.pc    = m_pc;
         e.instr = imem_word(m_pc);
         m_q.push_back(e);
         m_pc = m_pc + 32'd4;
      end
      m_run = en;
   endtask

   task automatic cycle(input bit rst, input bit en, input bit rv,
                        input logic [31:0] rpc, input bit rdy);
      i_rst            = rst;
      i_fetch_en       = en;
      i_redirect_valid = rv;
      i_redirect_pc    = rpc;
      i_if_ready       = rdy;
      model_edge(rst, en, rv, rpc, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic compare_model(input int cyc);
      logic [31:0] e_pc, e_instr;
      e_pc    = (m_q.size() != 0) ? m_q[0].pc    : 32'h0;
      e_instr = (m_q.size() != 0) ? m_q[0].instr : 32'h0;
      chk($sformatf("rnd%0d valid", cyc), 32'(o_if_valid), 32'(m_q.size() != 0));
      chk($sformatf("rnd%0d pc", cyc), o_if_pc, e_pc);
      chk($sformatf("rnd%0d instr", cyc), o_if_instr, e_instr);
      chk($sformatf("rnd%0d err", cyc), 32'(o_fetch_err), 32'(m_err));
      chk($sformatf("rnd%0d addr", cyc), 32'(o_imem_addr), 32'(m_pc[11:2]));
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          rst;
      bit          en;
      bit          rv;
      logic [31:0] rpc;
      bit          rdy;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      bit          e_err;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input bit rst, input bit en, input bit rv,
                               input logic [31:0] rpc, input bit rdy,
                               input bit ev, input logic [31:0] epc,
                               input logic [31:0] ein, input bit eerr,
                               input logic [31:0] eaddr);
      vec_t v;
      v.rst = rst; v.en = en; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_err = eerr; v.e_addr = eaddr;
      return v;
   endfunction

   initial begin
      logic [31:0] seen_pc;
      int          waited;
      bit          rst, en, rv, rdy;
      logic [31:0] rpc;

      i_rst = 1'b1; i_fetch_en = 1'b0; i_redirect_valid = 1'b0;
      i_redirect_pc = 32'h0; i_if_ready = 1'b0;

      //           rst en rv rpc          rdy  v  pc           instr          err addr
      // reset, start-up latency, steady streaming
      vecs.push_back(mk(1, 0, 0, 32'h0,   0,   0, 32'h0,  32'h0,          0,  0));
      vecs.push_back(mk(1, 0, 0, 32'h0,   0,   0, 32'h0,  32'h0,          0,  0));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   0, 32'h0,  32'h0,          0,  0));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'h0,  32'h1000_0000,  0,  1));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'h4,  32'h1000_0001,  0,  2));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'h8,  32'h1000_0002,  0,  3));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'hC,  32'h1000_0003,  0,  4));
      // back-pressure for five cycles, then release without a gap
      vecs.push_back(mk(1, 1, 0, 32'h0,   1,   0, 32'h0,  32'h0,          0,  0));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   0, 32'h0,  32'h0,          0,  0));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   1, 32'h0,  32'h1000_0000,  0,  1));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   1, 32'h0,  32'h1000_0000,  0,  2));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   1, 32'h0,  32'h1000_0000,  0,  2));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   1, 32'h0,  32'h1000_0000,  0,  2));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'h4,  32'h1000_0001,  0,  3));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'h8,  32'h1000_0002,  0,  4));
      // aligned redirect while holding pcs 8 and 12
      vecs.push_back(mk(0, 1, 1, 32'h40,  1,   0, 32'h0,  32'h0,          0, 16));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'h40, 32'h1000_0010,  0, 17));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'h44, 32'h1000_0011,  0, 18));
      // misaligned redirect
      vecs.push_back(mk(0, 1, 1, 32'h42,  1,   0, 32'h0,  32'h0,          1, 16));
      vecs.push_back(mk(0, 1, 0, 32'h0,   1,   1, 32'h40, 32'h1000_0010,  0, 17));
      // fill to two, then drain with fetch disabled
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   1, 32'h40, 32'h1000_0010,  0, 18));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1,   1, 32'h44, 32'h1000_0011,  0, 18));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1,   0, 32'h0,  32'h0,          0, 18));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1,   0, 32'h0,  32'h0,          0, 18));
      // refill, then reset with a coincident misaligned redirect
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   0, 32'h0,  32'h0,          0, 18));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   1, 32'h48, 32'h1000_0012,  0, 19));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0,   1, 32'h48, 32'h1000_0012,  0, 20));
      vecs.push_back(mk(1, 1, 1, 32'h82,  1,   0, 32'h0,  32'h0,          0,  0));
      vecs.push_back(mk(0, 0, 0, 32'h0,   0,   0, 32'h0,  32'h0,          0,  0));

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].rst, vecs[i].en, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
         chk($sformatf("vec%0d valid", i), 32'(o_if_valid), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d pc", i), o_if_pc, vecs[i].e_pc);
         chk($sformatf("vec%0d instr", i), o_if_instr, vecs[i].e_instr);
         chk($sformatf("vec%0d err", i), 32'(o_fetch_err), 32'(vecs[i].e_err));
         chk($sformatf("vec%0d addr", i), 32'(o_imem_addr), vecs[i].e_addr);
      end

      // Fill the FIFO under back-pressure, redirect with a coincident pop,
      // then expect the new stream one per cycle with no stale entries.
      cycle(0, 1, 0, 32'h0, 0);
      cycle(0, 1, 0, 32'h0, 0);
      cycle(0, 1, 0, 32'h0, 0);
      chk("seq full head", o_if_pc, 32'h0);
      cycle(0, 1, 1, 32'h100, 1);
      chk("seq flush valid", 32'(o_if_valid), 32'h0);
      waited = 0;
      while (!o_if_valid && waited < 10) begin
         cycle(0, 1, 0, 32'h0, 1);
         waited++;
      end
      chk("seq redirect latency", 32'(waited), 32'd1);
      for (int k = 0; k < 6; k++) begin
         seen_pc = o_if_valid ? o_if_pc : 32'hFFFF_FFFF;
         chk($sformatf("seq stream%0d pc", k), seen_pc, 32'h100 + 32'(4 * k));
         cycle(0, 1, 0, 32'h0, 1);
      end

      // Randomized traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) < 2);
         en  = ($urandom_range(0, 99) < 80);
         rv  = ($urandom_range(0, 99) < 10);
         rdy = ($urandom_range(0, 99) < 60);
         rpc = $urandom();
         cycle(rst, en, rv, rpc, rdy);
         compare_model(c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
